// File: rtl/alu_pkg.sv
// Shared ALU encodings: op codes from ALU control, branch compare types and the
// execute-stage FSM state encoding.
package alu_pkg;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SLL = 5'b00011;
  localparam logic [4:0] ALU_SRL = 5'b00100;
  localparam logic [4:0] ALU_XOR = 5'b00101;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_MUL = 5'b00111;
  localparam logic [4:0] ALU_DIV = 5'b01000;
  localparam logic [4:0] ALU_SRA = 5'b01001;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_NE = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;
  localparam logic [1:0] CMP_GE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative one-bit-per-cycle MUL/DIV engine. Only instantiated by alu_exec when
// ALU_EXEC_MULDIV_EN is defined.
// MUL: LSB-first shift-add, low XLEN bits of the product.
// DIV: restoring division on magnitudes, signed quotient fixup afterwards.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            last,
  output logic [XLEN-1:0] res
);

  localparam int unsigned SHW = $clog2(XLEN);

  // acc_q: product (MUL) or partial remainder (DIV)
  // lo_q:  multiplier (MUL) or dividend shifting into quotient (DIV)
  // hi_q:  multiplicand (MUL) or divisor magnitude (DIV)
  logic [XLEN-1:0] acc_q, lo_q, hi_q;
  logic [SHW-1:0]  cnt_q;
  logic            div_q, neg_q, dz_q;

  logic [XLEN-1:0] mag_a, mag_b, quo;
  logic [XLEN:0]   rem_sh, rem_diff;

  assign mag_a = op_a[XLEN-1] ? ('0 - op_a) : op_a;
  assign mag_b = op_b[XLEN-1] ? ('0 - op_b) : op_b;

  // Remainder never exceeds the divisor magnitude, so the extra MSB only flags borrow.
  assign rem_sh   = {acc_q, lo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, hi_q};

  assign last = step && (cnt_q == SHW'(XLEN - 1));

  // Sign fixup; divide-by-zero overrides to all-ones. MIN / -1 falls out naturally.
  assign quo = neg_q ? ('0 - lo_q) : lo_q;
  assign res = !div_q ? acc_q : (dz_q ? '1 : quo);

  // Operand load at acceptance, then one iteration per step cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      dz_q  <= 1'b0;
    end else if (load) begin
      acc_q <= '0;
      cnt_q <= '0;
      div_q <= is_div;
      if (is_div) begin
        lo_q  <= mag_a;
        hi_q  <= mag_b;
        neg_q <= op_a[XLEN-1] ^ op_b[XLEN-1];
        dz_q  <= (op_b == '0);
      end else begin
        lo_q  <= op_b;
        hi_q  <= op_a;
        neg_q <= 1'b0;
        dz_q  <= 1'b0;
      end
    end else if (step) begin
      cnt_q <= cnt_q + SHW'(1);
      if (div_q) begin
        lo_q  <= {lo_q[XLEN-2:0], !rem_diff[XLEN]};
        acc_q <= rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0];
      end else begin
        if (lo_q[0]) begin
          acc_q <= acc_q + hi_q;
        end
        lo_q <= lo_q >> 1;
        hi_q <= hi_q << 1;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle datapath, branch compare, FSM and registered
// outputs. Define ALU_EXEC_MULDIV_EN to include the iterative MUL/DIV engine;
// without it MUL and DIV behave as unknown op codes and busy is tied low.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      alu_op,
  input  logic [1:0]      cmp_type,
  input  logic            is_branch,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branch_taken,
  output logic            busy,
  output logic            done
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_e      state;
  logic [XLEN-1:0] sc_res, md_res;
  logic [SHW-1:0]  shamt;
  logic            cmp_hit, br_now, br_q;
  logic            md_op, md_div, md_last;

  assign shamt = op_b[SHW-1:0];

  // Single-cycle result; MUL, DIV and unknown codes fall to zero here
  always_comb begin
    case (alu_op)
      ALU_AND: sc_res = op_a & op_b;
      ALU_OR:  sc_res = op_a | op_b;
      ALU_ADD: sc_res = op_a + op_b;
      ALU_SLL: sc_res = op_a << shamt;
      ALU_SRL: sc_res = op_a >> shamt;
      ALU_XOR: sc_res = op_a ^ op_b;
      ALU_SUB: sc_res = op_a - op_b;
      ALU_SRA: sc_res = $signed(op_a) >>> shamt;
      default: sc_res = '0;
    endcase
  end

  // Branch compare on the raw operands, independent of alu_op
  always_comb begin
    case (cmp_type)
      CMP_EQ:  cmp_hit = (op_a == op_b);
      CMP_NE:  cmp_hit = (op_a != op_b);
      CMP_LT:  cmp_hit = ($signed(op_a) < $signed(op_b));
      default: cmp_hit = !($signed(op_a) < $signed(op_b));
    endcase
  end

  assign br_now = is_branch & cmp_hit;

`ifdef ALU_EXEC_MULDIV_EN
  logic md_load, md_step;

  assign md_op   = (alu_op == ALU_MUL) || (alu_op == ALU_DIV);
  assign md_div  = (alu_op == ALU_DIV);
  assign md_load = (state == ST_IDLE) && start && md_op;
  assign md_step = (state == ST_MUL) || (state == ST_DIV);
  assign busy    = (state != ST_IDLE);

  alu_muldiv_seq #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .load   (md_load),
    .step   (md_step),
    .is_div (md_div),
    .op_a   (op_a),
    .op_b   (op_b),
    .last   (md_last),
    .res    (md_res)
  );
`else
  assign md_op   = 1'b0;
  assign md_div  = 1'b0;
  assign md_last = 1'b0;
  assign md_res  = '0;
  assign busy    = 1'b0;
`endif

  // FSM plus output registers; outputs only move on the edge that raises done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      result       <= '0;
      zero         <= 1'b1;
      branch_taken <= 1'b0;
      done         <= 1'b0;
      br_q         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (md_op) begin
              state <= md_div ? ST_DIV : ST_MUL;
              br_q  <= br_now;
            end else begin
              result       <= sc_res;
              zero         <= (sc_res == '0);
              branch_taken <= br_now;
              done         <= 1'b1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_last) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          result       <= md_res;
          zero         <= (md_res == '0);
          branch_taken <= br_q;
          done         <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
